st_buf: RTL
===========

# st_buf

Store-side counterpart to the load data selector. Accepts byte/halfword/word store requests from the execute stage, aligns store data onto the 32-bit DMEM lane, generates per-byte write enables from the low address bits, and queues the result in a small FIFO that drains to DMEM over a valid/ready handshake. Also flags a load hazard when a pending store targets the same word as an incoming load.

## Interface
- DEPTH, 2: FIFO entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  buffer can accept; equals (count < DEPTH).
- sel  in  2  0 = STORE_BYTE, 1 = STORE_HALFWORD, 2 = STORE_WORD, 3 = invalid.
- addr  in  32  byte address of store.
- din  in  32  store data, right-justified (rs2).
- misalign_err  out  1  registered one-cycle pulse: an accepted request was rejected.
- mem_valid  out  1  head entry available (count != 0).
- mem_ready  in  1  DMEM takes head entry this cycle.
- mem_addr  out  32  word address {addr[31:2], 2'b00} of head entry.
- mem_wdata  out  32  aligned write data of head entry.
- mem_we  out  4  byte write enables of head entry; 4'b0000 when mem_valid = 0.
- ld_addr  in  32  address of load in execute.
- ld_hazard  out  1  some occupied entry has word address == ld_addr[31:2].
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Accept: req_valid && req_ready. Accepted request is either enqueued or rejected; it is never stalled further.
- Alignment on accept (o = addr[1:0]):
  - STORE_BYTE: wdata = {4{din[7:0]}}, we = 4'b0001 << o; always legal.
  - STORE_HALFWORD: wdata = {2{din[15:0]}}, we = 4'b0011 << o; legal only if o[0] = 0.
  - STORE_WORD: wdata = din, we = 4'b1111; legal only if o = 0.
  - sel = 3: illegal.
- Illegal accepted request: not enqueued, count unchanged, misalign_err = 1 the following cycle only.
- Entry stores {addr[31:2], wdata, we}; upper din bits outside the written lanes are don't-care but must equal the replicated pattern above.
- Dequeue: mem_valid && mem_ready; head pointer advances.
- FIFO: write/read pointers wrap modulo DEPTH; count tracks occupancy; enqueue and dequeue in the same cycle leave count unchanged.
- ld_hazard: combinational compare of ld_addr[31:2] against every occupied entry's word address; the request being accepted in the same cycle is not included. Byte enables are ignored (word-granular).

## Timing
- Reset (rst_n low, asynchronous): pointers 0, count 0, misalign_err 0, mem_valid 0, mem_we 0, ld_hazard 0 (given empty); mem_addr/mem_wdata 0. Reset mid-operation discards all entries.
- Accept-to-mem_valid latency: 1 cycle when empty (entry registered on accept edge).
- FIFO throughput: 1 store/cycle with mem_ready held high.
- req_ready depends only on registered count; no combinational path from mem_ready to req_ready. When full, a same-cycle dequeue does not open req_ready until the next cycle.
- mem_addr/mem_wdata/mem_we are driven from storage via the head pointer; stable while mem_valid && !mem_ready.
- misalign_err: registered, asserted exactly one cycle after the rejecting accept; back-to-back illegal requests give a continuous high.
- ld_hazard is combinational from ld_addr and registered state.

## Test plan
- Byte lanes: SB din=0x000000A5 at addr 0x1000..0x1003, mem_ready=1 -> mem_we 0001,0010,0100,1000; mem_wdata 0xA5A5A5A5; mem_addr 0x1000 each; each valid 1 cycle after accept.
- Halfword/word: SH din=0x1234BEEF addr 0x2002 -> we=1100, wdata=0xBEEFBEEF; SW din=0xDEADBEEF addr 0x2004 -> we=1111, wdata=0xDEADBEEF, mem_addr 0x2004.
- Misalign: SH addr 0x3001, SW addr 0x3002, sel=3 -> each accepted, misalign_err high next cycle, count stays 0, mem_valid stays 0.
- Full/backpressure: DEPTH=2, mem_ready=0, 3 back-to-back SW -> count 2, req_ready 0 on third; raise mem_ready with req_valid held -> entries emerge in order, third accepted cycle after the first dequeue; outputs stable while stalled.
- Hazard: enqueue SB addr 0x4003 with mem_ready=0; ld_addr 0x4000 -> ld_hazard 1; ld_addr 0x4004 -> 0; after dequeue -> 0.
- Reset: two entries queued, drop rst_n mid-cycle -> mem_valid, count, misalign_err, mem_we 0 immediately; after release, first new store appears at mem outputs with pointers restarted.

Source files
------------

// File: rtl/st_buf.sv
`default_nettype none
// ============================================================================
// Module   : st_buf
// Brief    : Store aligner and write-buffer FIFO draining to DMEM, with a
//            word-granular load hazard compare against pending entries.
// Revision : 1.0 - initial release
// ============================================================================
module st_buf #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               sel,
    input  logic [31:0]              addr,
    input  logic [31:0]              din,
    output logic                     misalign_err,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_we,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hazard,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    localparam logic [1:0] c_sel_byte = 2'd0;
    localparam logic [1:0] c_sel_half = 2'd1;
    localparam logic [1:0] c_sel_word = 2'd2;

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [DEPTH-1:0]   r_occ;
    logic [29:0]        r_waddr [DEPTH];
    logic [31:0]        r_wdata [DEPTH];
    logic [3:0]         r_we    [DEPTH];
    logic               r_misalign;

    logic               w_accept;
    logic               w_legal;
    logic               w_enq;
    logic               w_deq;
    logic [3:0]         w_we;
    logic [31:0]        w_wdata;
    logic               w_hazard;

    assign req_ready = (r_count < c_depth);
    assign mem_valid = (r_count != '0);
    assign w_accept  = req_valid && req_ready;
    assign w_enq     = w_accept && w_legal;
    assign w_deq     = mem_valid && mem_ready;

    // Lane replication makes every byte lane carry the store data so DMEM
    // only needs the byte enables to pick the written lanes.
    always_comb begin
        w_legal = 1'b0;
        w_we    = 4'b0000;
        w_wdata = din;
        case (sel)
            c_sel_byte: begin
                w_legal = 1'b1;
                w_we    = 4'b0001 << addr[1:0];
                w_wdata = {4{din[7:0]}};
            end
            c_sel_half: begin
                w_legal = ~addr[0];
                w_we    = 4'b0011 << addr[1:0];
                w_wdata = {2{din[15:0]}};
            end
            c_sel_word: begin
                w_legal = (addr[1:0] == 2'b00);
                w_we    = 4'b1111;
                w_wdata = din;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_occ      <= '0;
            r_misalign <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_waddr[i] <= '0;
                r_wdata[i] <= '0;
                r_we[i]    <= '0;
            end
        end else begin
            r_misalign <= w_accept && !w_legal;
            if (w_enq) begin
                r_waddr[r_wr_ptr] <= addr[31:2];
                r_wdata[r_wr_ptr] <= w_wdata;
                r_we[r_wr_ptr]    <= w_we;
                r_occ[r_wr_ptr]   <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            // Enqueue only happens when not full, so it never targets the head
            // slot while a dequeue clears it.
            if (w_deq) begin
                r_occ[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_occ[i] && (r_waddr[i] == ld_addr[31:2])) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign ld_hazard    = w_hazard;
    assign misalign_err = r_misalign;
    assign count        = r_count;
    assign mem_addr     = {r_waddr[r_rd_ptr], 2'b00};
    assign mem_wdata    = r_wdata[r_rd_ptr];
    assign mem_we       = mem_valid ? r_we[r_rd_ptr] : 4'b0000;

endmodule
`default_nettype wire
